// File: rtl/gf2_poly_div.sv
// gf2_poly_div: sequential long division of GF(2)[x] polynomials.
// A (2N-1)-bit dividend is divided by an N-bit divisor one coefficient per
// cycle, highest coefficient first. This takes exactly 2N-1 BUSY cycles for
// any operands. A zero divisor is reported through div_err without running
// the division. The result registers are only reloaded when a result is
// produced, so they keep the last delivered answer while idle or busy.
module gf2_poly_div #(
   parameter int N = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2*N-2:0]   dividend,
   input  logic [N-1:0]     divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2*N-2:0]   quotient,
   output logic [N-2:0]     remainder,
   output logic             div_err
);

   localparam int W  = 2*N-1;
   localparam int KW = $clog2(W);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    workRem_q, workRem_d;
   logic [N-1:0]    divisor_q, divisor_d;
   logic [KW-1:0]   deg_q, deg_d;
   logic [KW-1:0]   k_q, k_d;
   logic [W-1:0]    quot_q, quot_d;
   logic [W-1:0]    outQuot_q, outQuot_d;
   logic [N-2:0]    outRem_q, outRem_d;
   logic            divErr_q, divErr_d;

   logic [KW-1:0]   degIn;
   logic [W-1:0]    divisorExt;
   logic [KW-1:0]   shiftAmt;
   logic            stepHit;
   logic [W-1:0]    stepRem;
   logic [W-1:0]    stepQuot;
   logic [W-1:0]    quotOne;

   // The incoming divisor's degree is the index of its highest set bit.
   always_comb begin
      degIn = '0;
      for (int i = 0; i < N; i++) begin
         if (divisor[i]) begin
            degIn = KW'(i);
         end
      end
   end

   // One long-division step at coefficient k. When the leading coefficient
   // is set, the shifted divisor is cancelled out of it and the matching
   // quotient bit is recorded.
   always_comb begin
      divisorExt = {{(W-N){1'b0}}, divisor_q};
      quotOne    = {{(W-1){1'b0}}, 1'b1};
      shiftAmt   = k_q - deg_q;
      stepHit    = (k_q >= deg_q) && workRem_q[k_q];
      stepRem    = workRem_q;
      stepQuot   = quot_q;
      if (stepHit) begin
         stepRem  = workRem_q ^ (divisorExt << shiftAmt);
         stepQuot = quot_q | (quotOne << shiftAmt);
      end
   end

   // Next-state and datapath control for IDLE, BUSY and DONE.
   always_comb begin
      state_d   = state_q;
      workRem_d = workRem_q;
      divisor_d = divisor_q;
      deg_d     = deg_q;
      k_d       = k_q;
      quot_d    = quot_q;
      outQuot_d = outQuot_q;
      outRem_d  = outRem_q;
      divErr_d  = divErr_q;

      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               workRem_d = dividend;
               divisor_d = divisor;
               deg_d     = degIn;
               quot_d    = '0;
               if (divisor == '0) begin
                  k_d       = '0;
                  outQuot_d = '0;
                  outRem_d  = '0;
                  divErr_d  = 1'b1;
                  state_d   = DONE;
               end else begin
                  k_d     = KW'(W-1);
                  state_d = BUSY;
               end
            end
         end
         BUSY: begin
            workRem_d = stepRem;
            quot_d    = stepQuot;
            k_d       = k_q - 1'b1;
            if (k_q == '0) begin
               k_d       = '0;
               outQuot_d = stepQuot;
               outRem_d  = stepRem[N-2:0];
               divErr_d  = 1'b0;
               state_d   = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset clearing everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         workRem_q <= '0;
         divisor_q <= '0;
         deg_q     <= '0;
         k_q       <= '0;
         quot_q    <= '0;
         outQuot_q <= '0;
         outRem_q  <= '0;
         divErr_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         workRem_q <= workRem_d;
         divisor_q <= divisor_d;
         deg_q     <= deg_d;
         k_q       <= k_d;
         quot_q    <= quot_d;
         outQuot_q <= outQuot_d;
         outRem_q  <= outRem_d;
         divErr_q  <= divErr_d;
      end
   end

   assign in_ready  = (state_q == IDLE) && !rst;
   assign out_valid = (state_q == DONE);
   assign quotient  = outQuot_q;
   assign remainder = outRem_q;
   assign div_err   = divErr_q;

endmodule

// File: tb/tb_gf2_poly_div.sv
// Directed testbench for gf2_poly_div with N = 4 and hand-computed expected results.
module tb_gf2_poly_div;

   localparam int N = 4;

   logic           clk;
   logic           rst;
   logic           in_valid;
   logic           in_ready;
   logic [2*N-2:0] dividend;
   logic [N-1:0]   divisor;
   logic           out_valid;
   logic           out_ready;
   logic [2*N-2:0] quotient;
   logic [N-2:0]   remainder;
   logic           div_err;

   int compared   = 0;
   int mismatched = 0;

   gf2_poly_div #(.N(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dividend  (dividend),
      .divisor   (divisor),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .quotient  (quotient),
      .remainder (remainder),
      .div_err   (div_err)
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case something never terminates.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed no finish, expected finish before 200us");
      $fatal(1);
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [2*N-2:0] dvd, input logic [N-1:0] dvs);
      checkOutput("in_ready before accept", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      dividend = dvd;
      divisor  = dvs;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic waitValid(output int lat);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic runDivide(input string tag, input logic [2*N-2:0] dvd,
                            input logic [N-1:0] dvs, input logic [2*N-2:0] expQ,
                            input logic [N-2:0] expR, input logic expErr,
                            input int expLat);
      int lat;
      applyStimulus(dvd, dvs);
      waitValid(lat);
      checkOutput({tag, " latency"},   32'(lat),       32'(expLat));
      checkOutput({tag, " out_valid"}, 32'(out_valid), 32'd1);
      checkOutput({tag, " quotient"},  32'(quotient),  32'(expQ));
      checkOutput({tag, " remainder"}, 32'(remainder), 32'(expR));
      checkOutput({tag, " div_err"},   32'(div_err),   32'(expErr));
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      checkOutput({tag, " consumed out_valid"}, 32'(out_valid), 32'd0);
      checkOutput({tag, " consumed in_ready"},  32'(in_ready),  32'd1);
   endtask

   // Main directed sequence.
   initial begin
      int lat;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      dividend  = '0;
      divisor   = '0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset in_ready",  32'(in_ready),  32'd0);
      checkOutput("reset out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset quotient",  32'(quotient),  32'd0);
      checkOutput("reset remainder", 32'(remainder), 32'd0);
      checkOutput("reset div_err",   32'(div_err),   32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("post-reset in_ready", 32'(in_ready), 32'd1);

      runDivide("3A/6", 7'h3A, 4'h6, 7'h0B, 3'h0, 1'b0, 7);
      runDivide("3B/6", 7'h3B, 4'h6, 7'h0B, 3'h1, 1'b0, 7);
      runDivide("03/9", 7'h03, 4'h9, 7'h00, 3'h3, 1'b0, 7);
      runDivide("7F/0", 7'h7F, 4'h0, 7'h00, 3'h0, 1'b1, 0);

      // Result held for several cycles while in_valid pulses are ignored.
      applyStimulus(7'h7F, 4'hB);
      waitValid(lat);
      checkOutput("hold latency",  32'(lat),      32'd7);
      checkOutput("hold quotient", 32'(quotient), 32'h0D);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         dividend = 7'h3A;
         divisor  = 4'h0;
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         checkOutput("hold out_valid", 32'(out_valid), 32'd1);
         checkOutput("hold in_ready",  32'(in_ready),  32'd0);
         checkOutput("hold quotient",  32'(quotient),  32'h0D);
         checkOutput("hold remainder", 32'(remainder), 32'h0);
         checkOutput("hold div_err",   32'(div_err),   32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      checkOutput("hold release out_valid", 32'(out_valid), 32'd0);
      checkOutput("hold release in_ready",  32'(in_ready),  32'd1);

      // out_ready already high before the result appears.
      out_ready = 1'b1;
      applyStimulus(7'h55, 4'h1);
      waitValid(lat);
      checkOutput("55/1 latency",   32'(lat),       32'd7);
      checkOutput("55/1 quotient",  32'(quotient),  32'h55);
      checkOutput("55/1 remainder", 32'(remainder), 32'h0);
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      checkOutput("55/1 early-ready out_valid", 32'(out_valid), 32'd0);
      checkOutput("55/1 early-ready in_ready",  32'(in_ready),  32'd1);

      // Reset during the third BUSY cycle aborts the operation.
      applyStimulus(7'h3A, 4'h6);
      checkOutput("busy keeps last quotient", 32'(quotient), 32'h55);
      checkOutput("busy out_valid",           32'(out_valid), 32'd0);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      #1;
      checkOutput("rst high in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("abort out_valid", 32'(out_valid), 32'd0);
      checkOutput("abort quotient",  32'(quotient),  32'd0);
      checkOutput("abort remainder", 32'(remainder), 32'd0);
      checkOutput("abort div_err",   32'(div_err),   32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("abort in_ready", 32'(in_ready), 32'd1);
      lat = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) lat++;
      end
      checkOutput("abort no result", 32'(lat), 32'd0);
      runDivide("after abort 3B/6", 7'h3B, 4'h6, 7'h0B, 3'h1, 1'b0, 7);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/gf2_poly_div.md
GF2_POLY_DIV -- requirements
Module: gf2_poly_div

Interface
REQ-001 SHALL have parameter N, default 4, giving divisor width in bits (divisor degree <= N-1); N >= 2.
REQ-002 SHALL have clock port clk, input, 1 bit; all state updates on its rising edge.
REQ-003 SHALL have reset port rst, input, 1 bit; one clock, reset synchronous and active-high.
REQ-004 SHALL have in_valid, input, 1 bit: dividend/divisor valid.
REQ-005 SHALL have in_ready, output, 1 bit: block can accept an operand pair.
REQ-006 SHALL have dividend, input, 2N-1 bits: GF(2)[x] polynomial, bit i = coefficient of x^i.
REQ-007 SHALL have divisor, input, N bits: GF(2)[x] polynomial, same bit convention.
REQ-008 SHALL have out_valid, output, 1 bit: result valid.
REQ-009 SHALL have out_ready, input, 1 bit: consumer accepts result.
REQ-010 SHALL have quotient, output, 2N-1 bits: GF(2)[x] quotient.
REQ-011 SHALL have remainder, output, N-1 bits: GF(2)[x] remainder.
REQ-012 SHALL have div_err, output, 1 bit: divisor was zero.

Function
REQ-013 SHALL compute q, r with dividend = q*divisor XOR r over GF(2)[x], deg(r) < deg(divisor); all arithmetic carry-free (XOR).
REQ-014 SHALL implement FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-015 SHALL drive in_ready = 1 only in IDLE and only while rst = 0; out_valid = 1 only in DONE.
REQ-016 SHALL accept operands on a rising edge where in_valid = 1 and in_ready = 1, registering dividend into a working remainder register, divisor, and deg = index of the divisor's highest set bit; quotient register cleared.
REQ-017 SHALL, on acceptance with divisor = 0, go directly to DONE with div_err = 1, quotient = 0, remainder = 0 (out_valid one cycle after acceptance).
REQ-018 SHALL, on acceptance with divisor != 0, enter BUSY with step index k = 2N-2 and div_err = 0.
REQ-019 SHALL, in each BUSY cycle, when k >= deg and working-remainder bit k = 1: set quotient bit k-deg and XOR (divisor << (k-deg)) into the working remainder; otherwise leave both unchanged.
REQ-020 SHALL decrement k each BUSY cycle and move BUSY->DONE on the edge processing k = 0: exactly 2N-1 BUSY cycles, out_valid rising 2N-1 cycles after the accepting edge (7 for N = 4), regardless of operand values.
REQ-021 SHALL present remainder = working remainder bits [N-2:0] in DONE; higher bits are zero by construction.
REQ-022 SHALL hold quotient, remainder, div_err stable throughout DONE until consumed.
REQ-023 SHALL consume the result on a rising edge with out_valid = 1 and out_ready = 1, moving DONE->IDLE; out_ready already high when out_valid rises consumes on the first DONE edge.
REQ-024 SHALL ignore in_valid in BUSY and DONE; no new operands accepted until back in IDLE.
REQ-025 SHALL ignore out_ready outside DONE.
REQ-026 SHALL keep quotient, remainder, div_err at their last DONE values while in IDLE and BUSY (not valid unless out_valid = 1).

Reset
REQ-027 SHALL, on any edge with rst = 1, force state IDLE, out_valid = 0, quotient = 0, remainder = 0, div_err = 0, k = 0, working registers = 0.
REQ-028 SHALL abort any BUSY or DONE operation on reset with no result emitted; in_ready = 0 while rst = 1 and 1 on the first cycle after rst deasserts.

Verification
REQ-029 SHALL pass: N=4, dividend 7'h3A, divisor 4'h6 -> out_valid 7 cycles after accept, quotient 7'h0B, remainder 3'h0, div_err 0.
REQ-030 SHALL pass: dividend 7'h3B, divisor 4'h6 -> quotient 7'h0B, remainder 3'h1; dividend 7'h03, divisor 4'h9 -> quotient 7'h00, remainder 3'h3.
REQ-031 SHALL pass: dividend 7'h55, divisor 4'h1 -> quotient 7'h55, remainder 3'h0, latency still 7 cycles.
REQ-032 SHALL pass: divisor 4'h0, dividend 7'h7F -> out_valid 1 cycle after accept, div_err 1, quotient 0, remainder 0.
REQ-033 SHALL pass: out_ready held 0 for 5 DONE cycles -> outputs stable, in_ready 0, in_valid pulses ignored; out_ready 1 -> IDLE next edge, in_ready 1.
REQ-034 SHALL pass: rst asserted on 3rd BUSY cycle -> next edge state IDLE, out_valid 0, all outputs 0, no result emitted; new operands accepted after rst drops.
